// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM read and write paths.
//   VDD / VSS  : rail levels driven onto wordlines and bitlines
//   VTH        : sensing threshold used by the read-side sense amplifier
//   wr_state_t : write-driver sequencing states
//   to_real    : maps a logic bit onto a rail level
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.75;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE     = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } wr_state_t;

  function automatic real to_real(input logic b);
    return b ? VDD : VSS;
  endfunction

endpackage

// File: rtl/wl_decoder.sv
// wl_decoder: combinational one-hot wordline decoder producing rail levels.
// The read-side row selector reuses this block, so it carries no state;
// the instantiating module registers the result.
//   addr     in  AW         row to select
//   en       in  1          select enable; all rows at VSS when low
//   addr_bad in  1          address is outside the array; all rows at VSS
//   wl       out real[ROWS] wordline levels, at most one at VDD
module wl_decoder
  import sram_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  input  logic          addr_bad,
  output real           wl [0:ROWS-1]
);

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      wl[r] = to_real(en && !addr_bad && (32'(addr) == r));
    end
  end

endmodule

// File: rtl/sram_write_driver.sv
// sram_write_driver: write path into the mixed-signal SRAM array model.
// Accepts one (row, word) request through a valid/ready handshake, then
// sequences precharge -> wordline + bitline drive -> release on real-valued
// rail outputs. Every output (levels and pulses) is registered.
//   clk       in   1            rising-edge clock
//   rst       in   1            synchronous active-high reset
//   wr_req    in   1            request valid
//   wr_ready  out  1            idle, request will be accepted
//   wr_addr   in   AW           target row
//   wr_data   in   COLS         word to write, bit c -> column c
//   wr_done   out  1            one-cycle pulse in the release cycle
//   wr_err    out  1            pulses with wr_done when the row was out of range
//   row_wr    out  real[ROWS]   wordline levels
//   bl_wr     out  real[COLS]   bitline levels
//   blb_wr    out  real[COLS]   complementary bitline levels
//
// state   | meaning
// IDLE    | bitlines precharged high, wordlines low, ready for a request
// PRE     | precharge hold for PRE_CYC cycles, wordlines low
// DRIVE   | selected wordline high, bitlines carry the data for DRV_CYC cycles
// RELEASE | wordline low, data still on bitlines, wr_done/wr_err pulse
module sram_write_driver
  import sram_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int DRV_CYC = 3,
  parameter int AW      = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_req,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  output logic            wr_done,
  output logic            wr_err,
  output real             row_wr [0:ROWS-1],
  output real             bl_wr  [0:COLS-1],
  output real             blb_wr [0:COLS-1]
);

  localparam int CMAX = (PRE_CYC > DRV_CYC) ? PRE_CYC : DRV_CYC;
  localparam int CW   = $clog2(CMAX) + 1;

  wr_state_t       state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] data_q;
  logic            addr_bad;
  logic            dec_en;
  real             wl_next [0:ROWS-1];

  assign wr_ready = (state == IDLE);

  // The decoder is enabled for every cycle whose *next* state is DRIVE, so
  // that registering its output lines the wordline up with the state register.
  assign dec_en = ((state == PRE)   && (cnt == '0)) ||
                  ((state == DRIVE) && (cnt != '0));

  wl_decoder #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_wl_decoder (
    .addr     (addr_q),
    .en       (dec_en),
    .addr_bad (addr_bad),
    .wl       (wl_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      addr_bad <= 1'b0;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
      for (int r = 0; r < ROWS; r++) row_wr[r] <= VSS;
      for (int c = 0; c < COLS; c++) begin
        bl_wr[c]  <= VDD;
        blb_wr[c] <= VDD;
      end
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      for (int r = 0; r < ROWS; r++) row_wr[r] <= wl_next[r];

      case (state)
        IDLE: begin
          if (wr_req) begin
            addr_q   <= wr_addr;
            data_q   <= wr_data;
            addr_bad <= (32'(wr_addr) >= ROWS);
            cnt      <= CW'(PRE_CYC - 1);
            state    <= PRE;
          end
        end

        PRE: begin
          if (cnt == '0) begin
            cnt   <= CW'(DRV_CYC - 1);
            state <= DRIVE;
            for (int c = 0; c < COLS; c++) begin
              bl_wr[c]  <= to_real(data_q[c]);
              blb_wr[c] <= to_real(!data_q[c]);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DRIVE: begin
          if (cnt == '0) begin
            state   <= RELEASE;
            wr_done <= 1'b1;
            wr_err  <= addr_bad;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RELEASE: begin
          // Bitlines were held through the wordline fall; precharge them now.
          state <= IDLE;
          for (int c = 0; c < COLS; c++) begin
            bl_wr[c]  <= VDD;
            blb_wr[c] <= VDD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
